// File: rtl/mrd_stage_sched.sv
// rtl/mrd_stage_sched.sv - packet stage scheduler for the mixed-radix DFT memory (watchdog: MRD_STAGE_SCHED_WDOG_EN)
module mrd_stage_sched #(
    parameter int MAX_STAGES  = 6,
    parameter int wPTS        = 12,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sop_in,
    input  logic [wPTS-1:0] dftpts_in,
    input  logic [2:0]      nof_in,
    input  logic            sink_3_4,
    input  logic            rd_end,
    input  logic            wr_end,
    input  logic            source_end,
    output logic            accept_rdy,
    output logic [2:0]      fsm_state,
    output logic [2:0]      cnt_stage,
    output logic            last_stage,
    output logic            stage_start,
    output logic            src_start,
    output logic            pkt_done,
    output logic [wPTS-1:0] dftpts,
    output logic            sop_drop,
    output logic            err_timeout,
    output logic [15:0]     pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SINK = 3'd1,
        S_RD   = 3'd3,
        S_WAIT = 3'd4,
        S_SRC  = 3'd5
    } state_t;

    localparam logic [3:0] MAX_ST = 4'(MAX_STAGES);

    state_t          state, state_fsm, state_nxt;
    logic [2:0]      nof_q, nof_nxt, cnt_nxt;
    logic [wPTS-1:0] dft_nxt;
    logic            wr_pend_q, wr_pend_nxt;
    logic            sop_ok, progress, wd_fire, last_nxt;

    assign fsm_state = state;
    assign sop_ok    = (nof_in != 3'd0) && ({1'b0, nof_in} <= MAX_ST);

    // Next-state and datapath updates; the watchdog may override the FSM choice
    always_comb begin
        state_fsm   = state;
        nof_nxt     = nof_q;
        cnt_nxt     = cnt_stage;
        dft_nxt     = dftpts;
        wr_pend_nxt = wr_pend_q;
        progress    = 1'b0;
        case (state)
            S_IDLE: begin
                wr_pend_nxt = 1'b0;
                if (sop_in && sop_ok) begin
                    state_fsm = S_SINK;
                    nof_nxt   = nof_in;
                    dft_nxt   = dftpts_in;
                    cnt_nxt   = 3'd0;
                end
            end
            S_SINK: begin
                if (sink_3_4) begin
                    state_fsm = S_RD;
                    progress  = 1'b1;
                end
            end
            S_RD: begin
                if (wr_end) begin
                    wr_pend_nxt = 1'b1;
                    progress    = 1'b1;
                end
                if (rd_end) begin
                    state_fsm = S_WAIT;
                    progress  = 1'b1;
                end
            end
            S_WAIT: begin
                if (wr_end || wr_pend_q) begin
                    progress    = 1'b1;
                    wr_pend_nxt = 1'b0;
                    if (cnt_stage == nof_q - 3'd1) begin
                        state_fsm = S_SRC;
                    end else begin
                        state_fsm = S_RD;
                        cnt_nxt   = cnt_stage + 3'd1;
                    end
                end
            end
            S_SRC: begin
                if (source_end) begin
                    state_fsm = S_IDLE;
                    progress  = 1'b1;
                end
            end
            default: state_fsm = S_IDLE;
        endcase
        state_nxt = state_fsm;
        if (wd_fire) begin
            state_nxt   = S_IDLE;
            wr_pend_nxt = 1'b0;
        end
        last_nxt = ((state_nxt == S_RD) || (state_nxt == S_WAIT) || (state_nxt == S_SRC)) &&
                   ((cnt_nxt == nof_nxt - 3'd1) || (state_nxt == S_SRC));
    end

    // State, packet context, registered strobes and completed-packet counter
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= S_IDLE;
            nof_q       <= 3'd0;
            cnt_stage   <= 3'd0;
            dftpts      <= '0;
            wr_pend_q   <= 1'b0;
            accept_rdy  <= 1'b1;
            last_stage  <= 1'b0;
            stage_start <= 1'b0;
            src_start   <= 1'b0;
            pkt_done    <= 1'b0;
            sop_drop    <= 1'b0;
            pkt_cnt     <= 16'd0;
        end else begin
            state       <= state_nxt;
            nof_q       <= nof_nxt;
            cnt_stage   <= cnt_nxt;
            dftpts      <= dft_nxt;
            wr_pend_q   <= wr_pend_nxt;
            accept_rdy  <= (state_nxt == S_IDLE);
            last_stage  <= last_nxt;
            stage_start <= (state_nxt == S_RD) && (state != S_RD);
            src_start   <= (state_nxt == S_SRC) && (state != S_SRC);
            pkt_done    <= (state == S_SRC) && source_end;
            sop_drop    <= sop_in && !((state == S_IDLE) && sop_ok);
            if ((state == S_SRC) && source_end) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

`ifdef MRD_STAGE_SCHED_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_fire = (state != S_IDLE) && !progress && (state_fsm == state) &&
                     (wd_cnt == WDW'(TIMEOUT_CYC - 1));

    // Idle-progress counter; restarts on any state change or accepted pulse
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if ((state == S_IDLE) || progress || (state_fsm != state) || wd_fire) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0) ^ progress;
    assign wd_fire            = 1'b0;
    assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_stage_sched.sv
// tb/tb_mrd_stage_sched.sv - scoreboard testbench for mrd_stage_sched
module tb_mrd_stage_sched;

    logic        clk;
    logic        rst_n;
    logic        sop_in;
    logic [11:0] dftpts_in;
    logic [2:0]  nof_in;
    logic        sink_3_4;
    logic        rd_end;
    logic        wr_end;
    logic        source_end;
    logic        accept_rdy;
    logic [2:0]  fsm_state;
    logic [2:0]  cnt_stage;
    logic        last_stage;
    logic        stage_start;
    logic        src_start;
    logic        pkt_done;
    logic [11:0] dftpts;
    logic        sop_drop;
    logic        err_timeout;
    logic [15:0] pkt_cnt;

    mrd_stage_sched #(.MAX_STAGES(6), .wPTS(12), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .sop_in(sop_in), .dftpts_in(dftpts_in),
        .nof_in(nof_in), .sink_3_4(sink_3_4), .rd_end(rd_end), .wr_end(wr_end),
        .source_end(source_end), .accept_rdy(accept_rdy), .fsm_state(fsm_state),
        .cnt_stage(cnt_stage), .last_stage(last_stage), .stage_start(stage_start),
        .src_start(src_start), .pkt_done(pkt_done), .dftpts(dftpts),
        .sop_drop(sop_drop), .err_timeout(err_timeout), .pkt_cnt(pkt_cnt)
    );

    // inputs {rst, sop, sink_3_4, rd_end, wr_end, source_end}
    localparam logic [5:0] I_N   = 6'b000000;
    localparam logic [5:0] I_R   = 6'b100000;
    localparam logic [5:0] I_SOP = 6'b010000;
    localparam logic [5:0] I_S34 = 6'b001000;
    localparam logic [5:0] I_RD  = 6'b000100;
    localparam logic [5:0] I_WR  = 6'b000010;
    localparam logic [5:0] I_SE  = 6'b000001;
    // pulses {stage_start, src_start, pkt_done, sop_drop}
    localparam logic [3:0] P_0   = 4'b0000;
    localparam logic [3:0] P_SS  = 4'b1000;
    localparam logic [3:0] P_SRC = 4'b0100;
    localparam logic [3:0] P_PD  = 4'b0010;
    localparam logic [3:0] P_DR  = 4'b0001;

    typedef struct {
        logic [2:0]  st;
        logic [2:0]  cs;
        logic [3:0]  pl;
        logic        acc;
        logic        last;
        logic [15:0] pk;
        logic [11:0] dft;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_pkts = 16'd0;
    logic [11:0] exp_dft  = 12'd0;
    logic [2:0]  exp_nof  = 3'd0;
    logic        exp_err  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // drive one cycle of stimulus and push the expected post-edge outputs
    task automatic cyc(input logic [5:0] in_v, input logic [2:0] nof_v, input logic [11:0] dft_v,
                       input logic [2:0] st, input logic [2:0] cs, input logic [3:0] pl);
        exp_t e;
        @(negedge clk);
        {rst_n, sop_in, sink_3_4, rd_end, wr_end, source_end} = in_v;
        nof_in    = nof_v;
        dftpts_in = dft_v;
        if (in_v[5]) begin
            exp_pkts = 16'd0;
            exp_dft  = 12'd0;
            exp_nof  = 3'd0;
            exp_err  = 1'b0;
        end
        if (pl[1]) exp_pkts = exp_pkts + 16'd1;
        e.st   = st;
        e.cs   = cs;
        e.pl   = pl;
        e.acc  = (st == 3'd0);
        e.last = ((st == 3'd3) || (st == 3'd4) || (st == 3'd5)) &&
                 ((cs == exp_nof - 3'd1) || (st == 3'd5));
        e.pk   = exp_pkts;
        e.dft  = exp_dft;
        e.err  = exp_err;
        sb.push_back(e);
    endtask

    // compare DUT outputs just after each active edge against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("fsm_state", 32'(fsm_state), 32'(mon_e.st));
            chk("cnt_stage", 32'(cnt_stage), 32'(mon_e.cs));
            chk("pulses", 32'({stage_start, src_start, pkt_done, sop_drop}), 32'(mon_e.pl));
            chk("accept_rdy", 32'(accept_rdy), 32'(mon_e.acc));
            chk("last_stage", 32'(last_stage), 32'(mon_e.last));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(mon_e.pk));
            chk("dftpts", 32'(dftpts), 32'(mon_e.dft));
            chk("err_timeout", 32'(err_timeout), 32'(mon_e.err));
        end
    end

    task automatic one_stage_pkt(input logic [11:0] dft_v);
        exp_nof = 3'd1;
        exp_dft = dft_v;
        cyc(I_SOP, 3'd1, dft_v, 3'd1, 3'd0, P_0);
        cyc(I_S34, 3'd0, 12'd0, 3'd3, 3'd0, P_SS);
        cyc(I_RD,  3'd0, 12'd0, 3'd4, 3'd0, P_0);
        cyc(I_WR,  3'd0, 12'd0, 3'd5, 3'd0, P_SRC);
        cyc(I_SE,  3'd0, 12'd0, 3'd0, 3'd0, P_PD);
    endtask

    initial begin
        {rst_n, sop_in, sink_3_4, rd_end, wr_end, source_end} = I_R;
        nof_in    = 3'd0;
        dftpts_in = 12'd0;

        cyc(I_R, 3'd0, 12'd0, 3'd0, 3'd0, P_0);
        cyc(I_N, 3'd0, 12'd0, 3'd0, 3'd0, P_0);

        // full packet, nof=3, dftpts=1200
        exp_nof = 3'd3;
        exp_dft = 12'd1200;
        cyc(I_SOP, 3'd3, 12'd1200, 3'd1, 3'd0, P_0);
        cyc(I_N,   3'd0, 12'd0,    3'd1, 3'd0, P_0);
        cyc(I_S34, 3'd0, 12'd0,    3'd3, 3'd0, P_SS);
        cyc(I_N,   3'd0, 12'd0,    3'd3, 3'd0, P_0);
        cyc(I_RD,  3'd0, 12'd0,    3'd4, 3'd0, P_0);
        cyc(I_WR,  3'd0, 12'd0,    3'd3, 3'd1, P_SS);
        cyc(I_RD,  3'd0, 12'd0,    3'd4, 3'd1, P_0);
        cyc(I_WR,  3'd0, 12'd0,    3'd3, 3'd2, P_SS);
        cyc(I_RD,  3'd0, 12'd0,    3'd4, 3'd2, P_0);
        cyc(I_WR,  3'd0, 12'd0,    3'd5, 3'd2, P_SRC);
        cyc(I_N,   3'd0, 12'd0,    3'd5, 3'd2, P_0);
        cyc(I_SE,  3'd0, 12'd0,    3'd0, 3'd2, P_PD);
        cyc(I_N,   3'd0, 12'd0,    3'd0, 3'd2, P_0);

        // rd_end and wr_end together at stage 0 of nof=2, then sop during Source
        exp_nof = 3'd2;
        exp_dft = 12'd64;
        cyc(I_SOP,        3'd2, 12'd64, 3'd1, 3'd0, P_0);
        cyc(I_S34,        3'd0, 12'd0,  3'd3, 3'd0, P_SS);
        cyc(I_RD | I_WR,  3'd0, 12'd0,  3'd4, 3'd0, P_0);
        cyc(I_N,          3'd0, 12'd0,  3'd3, 3'd1, P_SS);
        cyc(I_RD,         3'd0, 12'd0,  3'd4, 3'd1, P_0);
        cyc(I_N,          3'd0, 12'd0,  3'd4, 3'd1, P_0);
        cyc(I_WR,         3'd0, 12'd0,  3'd5, 3'd1, P_SRC);
        cyc(I_SOP,        3'd2, 12'd99, 3'd5, 3'd1, P_DR);
        cyc(I_SE,         3'd0, 12'd0,  3'd0, 3'd1, P_PD);

        // illegal nof in Idle, and stray pulses in Idle
        cyc(I_SOP, 3'd0, 12'd5, 3'd0, 3'd1, P_DR);
        cyc(I_SOP, 3'd7, 12'd5, 3'd0, 3'd1, P_DR);
        cyc(I_S34 | I_RD | I_WR | I_SE, 3'd0, 12'd0, 3'd0, 3'd1, P_0);

        // sop during Rd, then reset in stage 2 Wait_wr_end
        exp_nof = 3'd4;
        exp_dft = 12'd512;
        cyc(I_SOP, 3'd4, 12'd512, 3'd1, 3'd0, P_0);
        cyc(I_S34, 3'd0, 12'd0,   3'd3, 3'd0, P_SS);
        cyc(I_SOP, 3'd3, 12'd7,   3'd3, 3'd0, P_DR);
        cyc(I_RD,  3'd0, 12'd0,   3'd4, 3'd0, P_0);
        cyc(I_WR,  3'd0, 12'd0,   3'd3, 3'd1, P_SS);
        cyc(I_RD,  3'd0, 12'd0,   3'd4, 3'd1, P_0);
        cyc(I_WR,  3'd0, 12'd0,   3'd3, 3'd2, P_SS);
        cyc(I_RD,  3'd0, 12'd0,   3'd4, 3'd2, P_0);
        cyc(I_R | I_WR, 3'd0, 12'd0, 3'd0, 3'd0, P_0);
        one_stage_pkt(12'd16);

        // wr_end arriving in Rd before rd_end is held as pending
        exp_nof = 3'd1;
        exp_dft = 12'd32;
        cyc(I_SOP, 3'd1, 12'd32, 3'd1, 3'd0, P_0);
        cyc(I_S34, 3'd0, 12'd0,  3'd3, 3'd0, P_SS);
        cyc(I_WR,  3'd0, 12'd0,  3'd3, 3'd0, P_0);
        cyc(I_RD,  3'd0, 12'd0,  3'd4, 3'd0, P_0);
        cyc(I_N,   3'd0, 12'd0,  3'd5, 3'd0, P_SRC);
        cyc(I_SE,  3'd0, 12'd0,  3'd0, 3'd0, P_PD);

        // packet counter wrap from a preset value
        @(negedge clk);
        force dut.pkt_cnt = 16'hFFFE;
        @(posedge clk);
        #2;
        release dut.pkt_cnt;
        exp_pkts = 16'hFFFE;
        one_stage_pkt(12'd8);
        one_stage_pkt(12'd9);

        // stall in Rd without rd_end
        exp_nof = 3'd2;
        exp_dft = 12'd77;
        cyc(I_SOP, 3'd2, 12'd77, 3'd1, 3'd0, P_0);
        cyc(I_S34, 3'd0, 12'd0,  3'd3, 3'd0, P_SS);
        for (int i = 1; i <= 70; i++) begin
`ifdef MRD_STAGE_SCHED_WDOG_EN
            if (i == 64) exp_err = 1'b1;
            cyc(I_N, 3'd0, 12'd0, (i < 64) ? 3'd3 : 3'd0, 3'd0, P_0);
`else
            cyc(I_N, 3'd0, 12'd0, 3'd3, 3'd0, P_0);
`endif
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mrd_stage_sched.md
# mrd_stage_sched

Packet-level stage scheduler for the mixed-radix DFT memory subsystem. It admits one packet at a time and sequences it through Sink, one Rd/Wait_wr_end pair per radix factor, and Source. It drives the stage number, stage-start and source-start strobes consumed by the RAM-bank read/write/source engines. It is the single owner of packet progress, with optional watchdog recovery.

## Interface
- MAX_STAGES, 6, maximum number of radix factors per packet
- wPTS, 12, width of dftpts
- TIMEOUT_CYC, 8192, watchdog limit in cycles (used only with the watchdog macro)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-high (1 = reset), despite the name
- sop_in  in  1  first sample of an input packet
- dftpts_in  in  wPTS  packet DFT length, valid with sop_in
- nof_in  in  3  NumOfFactors, valid with sop_in
- sink_3_4  in  1  sink engine has written 3/4 of the packet
- rd_end  in  1  one-cycle pulse: butterfly reads of the current stage done
- wr_end  in  1  one-cycle pulse: write-back of the current stage done
- source_end  in  1  one-cycle pulse: last output sample issued
- accept_rdy  out  1  1 only in Idle
- fsm_state  out  3  Idle=0, Sink=1, Rd=3, Wait_wr_end=4, Source=5
- cnt_stage  out  3  current stage index, 0-based
- last_stage  out  1  cnt_stage == nof-1, or state == Source
- stage_start  out  1  pulse, first cycle of every Rd entry
- src_start  out  1  pulse, first cycle of Source
- pkt_done  out  1  pulse, first Idle cycle after Source
- dftpts  out  wPTS  dftpts latched at an accepted sop
- sop_drop  out  1  pulse: sop_in rejected
- err_timeout  out  1  sticky watchdog flag
- pkt_cnt  out  16  completed-packet counter, wraps 0xFFFF->0

## Operation
- State machine transitions:
  - Idle -> Sink on sop_in with 1 <= nof_in <= MAX_STAGES. Latch nof and dftpts; set cnt_stage = 0.
  - Sink -> Rd on sink_3_4.
  - Rd -> Wait_wr_end on rd_end.
  - Wait_wr_end on wr_end (or wr_pend): go to Source if cnt_stage == nof-1; otherwise go to Rd and increment cnt_stage on the same edge.
  - Source -> Idle on source_end.
- Illegal encodings in fsm_state return to Idle on the next edge.
- sop_drop pulses when sop_in arrives outside Idle, or in Idle with nof_in 0 or > MAX_STAGES. In either case the state is unchanged.
- wr_pend: set when wr_end arrives in Rd, including in the same cycle as rd_end. Consumed on the Wait_wr_end exit; cleared in Idle.
- rd_end outside Rd and wr_end outside Rd or Wait_wr_end are ignored.
- source_end outside Source is ignored.
- pkt_cnt increments when pkt_done pulses.

## Timing
- All outputs are registered. Reset values:
  - state = Idle, accept_rdy = 1
  - cnt_stage, dftpts, pkt_cnt, all pulses, wr_pend and err_timeout = 0
  - last_stage = 0
- Reset asserted mid-packet: Idle on the next edge. No pulses are emitted.
- sop_in at edge N -> fsm_state = Sink and accept_rdy = 0 after edge N.
- Strobe timing:
  - stage_start is high exactly during the first cycle in which fsm_state reads Rd.
  - src_start and pkt_done are aligned the same way to Source and Idle.
- Minimum Wait_wr_end dwell is one cycle, even with wr_pend set.
- nof = 1: Sink -> Rd -> Wait_wr_end -> Source. last_stage is high from Rd entry onward.
- Event to response: one edge for every transition.

## Configuration
- Macro MRD_STAGE_SCHED_WDOG_EN.
- Defined:
  - An idle-progress counter runs in every non-Idle state.
  - It clears on any state change or accepted input pulse.
  - When it reaches TIMEOUT_CYC, err_timeout sets (sticky until reset), state is forced to Idle and wr_pend is cleared.
  - No pkt_done is emitted and pkt_cnt is unchanged.
- Undefined: no counter is built; err_timeout is tied to 0.

## Test plan
- Full packet, nof=3, dftpts=1200: sop, sink_3_4, three rd_end/wr_end pairs, source_end -> states 0,1,3,4,3,4,3,4,5,0; stage_start x3; cnt_stage 0,1,2; src_start x1; pkt_done x1; pkt_cnt=1.
- rd_end and wr_end in the same cycle, stage 0 of nof=2 -> wr_pend set; one cycle in Wait_wr_end; Rd re-entered with cnt_stage=1.
- sop_in during Rd, and sop_in in Idle with nof_in=0 or 7 -> sop_drop pulse each time; state and cnt_stage unchanged.
- Reset during stage 2 Wait_wr_end -> Idle, cnt_stage=0, accept_rdy=1 next cycle; a following packet completes normally.
- With WDOG_EN and TIMEOUT_CYC=64: hold in Rd without rd_end -> err_timeout=1 at cycle 64, Idle, pkt_cnt unchanged. Without the macro, the same stimulus stays in Rd indefinitely.
- pkt_cnt preset near wrap by running 65536 nof=1 packets (or by force) -> pkt_cnt rolls 0xFFFF -> 0x0000.
